main_control_fsm: RTL and testbench

- Multicycle RISC-V main controller. Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath enables and mux selects.
- Produces the 2-bit ALUOp consumed by the ALU decoder (00 = add, 01 = subtract, 10 = decode from funct3/funct7).
- Sits beside the ALU decoder and the immediate extender inside the multicycle control unit.

---
 rtl/main_control_fsm_if.sv | 34 +++
 rtl/main_control_fsm.sv | 154 +++++++++++++++
 tb/tb_main_control_fsm.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/main_control_fsm_if.sv
// Control bundle between the multicycle main controller and the datapath.
// The controller drives the enables/selects; the datapath supplies the
// opcode, the ALU zero flag and the memory ready strobe.
interface main_control_fsm_if;
  logic [6:0] op;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       IllegalOp;
  logic [3:0] State;

  // Controller side
  modport master (
    input  op, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, ImmSrc, RegWrite, IllegalOp, State
  );

  // Datapath side
  modport slave (
    output op, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, ImmSrc, RegWrite, IllegalOp, State
  );
endinterface

// File: rtl/main_control_fsm.sv
// Multicycle RISC-V main controller: walks each instruction through
// fetch/decode/execute/memory/writeback and decodes datapath controls
// from the current state.
module main_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  main_control_fsm_if.master    bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t state_reg;
  logic   mem_ready;
  logic   pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;

  // Without the handshake, memory is assumed to finish every access in one cycle.
  assign mem_ready = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

  // State register; unreachable codes fall back to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
    end else begin
      case (state_reg)
        FETCH:    if (mem_ready) state_reg <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state_reg <= MEMADR;
            OP_R:         state_reg <= EXECUTER;
            OP_I:         state_reg <= EXECUTEI;
            OP_JAL:       state_reg <= JAL;
            OP_BEQ:       state_reg <= BEQ;
            default:      state_reg <= FETCH;
          endcase
        end
        MEMADR:   state_reg <= (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  if (mem_ready) state_reg <= MEMWB;
        MEMWB:    state_reg <= FETCH;
        MEMWRITE: if (mem_ready) state_reg <= FETCH;
        EXECUTER: state_reg <= ALUWB;
        EXECUTEI: state_reg <= ALUWB;
        ALUWB:    state_reg <= FETCH;
        JAL:      state_reg <= ALUWB;
        BEQ:      state_reg <= FETCH;
        default:  state_reg <= FETCH;
      endcase
    end
  end

  // Control decode from the current state, with the few input-gated enables.
  always_comb begin
    pc_write_raw   = 1'b0;
    mem_write_raw  = 1'b0;
    ir_write_raw   = 1'b0;
    reg_write_raw  = 1'b0;
    illegal_raw    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUOp      = 2'b00;
    case (state_reg)
      FETCH: begin
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        ir_write_raw  = mem_ready;
        pc_write_raw  = mem_ready;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        case (bus.op)
          OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: illegal_raw = 1'b0;
          default:                                  illegal_raw = 1'b1;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
      end
      MEMREAD: bus.AdrSrc = 1'b1;
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        bus.AdrSrc    = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECUTER: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b10;
      end
      EXECUTEI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 2'b10;
      end
      ALUWB: reg_write_raw = 1'b1;
      JAL: begin
        bus.ALUSrcA  = 2'b01;
        bus.ALUSrcB  = 2'b10;
        pc_write_raw = 1'b1;
      end
      BEQ: begin
        bus.ALUSrcA  = 2'b10;
        bus.ALUOp    = 2'b01;
        pc_write_raw = bus.Zero;
      end
      default: begin
      end
    endcase
  end

  // Enables drop the instant reset asserts, independent of the clock.
  assign bus.PCWrite   = pc_write_raw  & rst_n;
  assign bus.MemWrite  = mem_write_raw & rst_n;
  assign bus.IRWrite   = ir_write_raw  & rst_n;
  assign bus.RegWrite  = reg_write_raw & rst_n;
  assign bus.IllegalOp = illegal_raw   & rst_n;
  assign bus.State     = state_reg;

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_BEQ:  bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for the multicycle main controller: a per-instruction path model
// predicts state and controls every cycle under random stimulus, plus
// directed sequences with literal expectations.
module tb_main_control_fsm;
  logic clk;
  logic rst_n;
  main_control_fsm_if bus ();

  main_control_fsm #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;
  localparam logic [13:0] RESET_VEC = {4'b0000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};

  int errors = 0;
  int checks = 0;
  int path [8];
  int plen = 0;
  int idx = 0;
  logic [6:0] cur_op;
  logic [31:0] trace;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == JL) || (o == BQ);
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // States visited by one instruction, from its FETCH to its last state.
  function automatic void build_path(input logic [6:0] o);
    path = '{0, 1, 0, 0, 0, 0, 0, 0};
    case (o)
      LW: begin path[2] = 2; path[3] = 3; path[4] = 4; plen = 5; end
      SW: begin path[2] = 2; path[3] = 5; plen = 4; end
      RT: begin path[2] = 6; path[3] = 7; plen = 4; end
      IT: begin path[2] = 8; path[3] = 7; plen = 4; end
      JL: begin path[2] = 9; path[3] = 7; plen = 4; end
      BQ: begin path[2] = 10; plen = 3; end
      default: plen = 2;
    endcase
  endfunction

  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, RegWrite, IllegalOp}
  function automatic logic [13:0] exp_vec(input int code, input logic [6:0] o,
                                          input logic mr, input logic z);
    case (code)
      0:  return {mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
      1:  return {4'b0000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, !legal(o)};
      2:  return {4'b0000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
      3:  return {4'b0100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      4:  return {4'b0000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
      5:  return {4'b0110, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      6:  return {4'b0000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
      7:  return {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
      8:  return {4'b0000, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
      9:  return {4'b1000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
      10: return {z, 3'b000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
      default: return 14'h0;
    endcase
  endfunction

  function automatic logic [13:0] dut_vec();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RegWrite, bus.IllegalOp};
  endfunction

  // One clock cycle: drive inputs after the edge, compare mid-cycle, advance model.
  task automatic cycle(input logic [6:0] op_new, input logic mr, input logic z);
    int code;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    if (idx >= plen) begin
      cur_op = op_new;
      build_path(cur_op);
      idx = 0;
    end
    bus.op = cur_op;
    bus.MemReady = mr;
    bus.Zero = z;
    #3;
    code = path[idx];
    trace = {trace[27:0], bus.State};
    chk("state", int'(bus.State), code);
    chk($sformatf("outputs@s%0d", code), int'(dut_vec()), int'(exp_vec(code, cur_op, mr, z)));
    chk("immsrc", int'(bus.ImmSrc), int'(exp_imm(cur_op)));
    if (!((code == 0 || code == 3 || code == 5) && !mr)) idx++;
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.MemReady = 1'b1;
      bus.Zero = 1'b1;
      #3;
      chk("reset_state", int'(bus.State), 0);
      chk("reset_outputs", int'(dut_vec()), int'(RESET_VEC));
    end
  endtask

  // Assert reset between clock edges and confirm enables fall at once.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_state", int'(bus.State), 0);
    chk("async_enables", int'({bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.IllegalOp}), 0);
    idx = plen;
    hold_reset(1);
  endtask

  initial begin
    logic [6:0] ops [7];
    logic [6:0] o;
    rst_n = 1'b0;
    bus.op = 7'h0;
    bus.Zero = 1'b0;
    bus.MemReady = 1'b1;
    cur_op = 7'h0;
    trace = 32'h0;

    // Pin the model: cycles per instruction with MemReady tied high.
    ops = '{LW, SW, RT, IT, JL, BQ, BAD};
    build_path(LW); chk("cpi_lw", plen, 5);
    build_path(SW); chk("cpi_sw", plen, 4);
    build_path(RT); chk("cpi_r", plen, 4);
    build_path(IT); chk("cpi_i", plen, 4);
    build_path(JL); chk("cpi_jal", plen, 4);
    build_path(BQ); chk("cpi_beq", plen, 3);
    idx = plen;

    hold_reset(2);

    // R-type: 0,1,6,7,0
    for (int i = 0; i < 5; i++) cycle(RT, 1'b1, 1'b0);
    chk("rtype_trace", int'(trace[19:0]), 32'h01670);

    // lw with two stall cycles in MEMREAD
    async_reset();
    cycle(LW, 1, 0); cycle(LW, 1, 0); cycle(LW, 1, 0);
    cycle(LW, 0, 0); cycle(LW, 0, 0); cycle(LW, 1, 0);
    chk("lw_memread_adrsrc", int'(bus.AdrSrc), 1);
    cycle(LW, 1, 0); cycle(LW, 1, 0);
    chk("lw_trace", int'(trace), 32'h01233340);

    // sw, then reset in the middle of MEMWRITE
    async_reset();
    cycle(SW, 1, 0); cycle(SW, 1, 0); cycle(SW, 1, 0); cycle(SW, 0, 0);
    chk("sw_memwrite", int'(bus.MemWrite), 1);
    chk("sw_immsrc", int'(bus.ImmSrc), 1);
    async_reset();
    cycle(SW, 1, 0);
    chk("post_reset_irwrite", int'(bus.IRWrite), 1);
    chk("post_reset_pcwrite", int'(bus.PCWrite), 1);

    // beq taken and not taken
    async_reset();
    cycle(BQ, 1, 0); cycle(BQ, 1, 0); cycle(BQ, 1, 1);
    chk("beq_taken_pcwrite", int'(bus.PCWrite), 1);
    chk("beq_aluop", int'(bus.ALUOp), 1);
    chk("beq_trace", int'(trace[11:0]), 32'h01A);
    cycle(BQ, 1, 0); cycle(BQ, 1, 0); cycle(BQ, 1, 0);
    chk("beq_not_taken_pcwrite", int'(bus.PCWrite), 0);

    // jal: 0,1,9,7
    async_reset();
    cycle(JL, 1, 0); cycle(JL, 1, 0); cycle(JL, 1, 0);
    chk("jal_pcwrite", int'(bus.PCWrite), 1);
    cycle(JL, 1, 0);
    chk("jal_trace", int'(trace[15:0]), 32'h0197);

    // illegal opcode
    async_reset();
    cycle(BAD, 1, 0); cycle(BAD, 1, 0);
    chk("illegal_flag", int'(bus.IllegalOp), 1);
    cycle(BAD, 1, 0);
    chk("illegal_back_to_fetch", int'(bus.State), 0);
    chk("illegal_flag_cleared", int'(bus.IllegalOp), 0);

    // Randomized run with occasional asynchronous resets
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) o = 7'($urandom_range(0, 127));
      else o = ops[$urandom_range(0, 5)];
      cycle(o, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
